// File: rtl/shift_pkg.sv
// Shared op encodings and stage-register payload type for the pipelined shifter.
package shift_pkg;

    typedef logic [2:0] shift_op_t;

    localparam shift_op_t SHIFT_OP_SLL = 3'b000;
    localparam shift_op_t SHIFT_OP_SRL = 3'b001;
    localparam shift_op_t SHIFT_OP_SRA = 3'b010;
    localparam shift_op_t SHIFT_OP_ROL = 3'b011;
    localparam shift_op_t SHIFT_OP_ROR = 3'b100;

    // Type holder so the stage register can be sized by the instantiating module.
    virtual class shift_stage_types #(
        parameter int unsigned XLEN  = 32,
        parameter int unsigned TAG_W = 5
    );
        typedef struct packed {
            logic                    valid;
            logic [XLEN-1:0]         data;
            shift_op_t               op;
            logic                    word;
            logic [$clog2(XLEN)-1:0] shamt;
            logic [TAG_W-1:0]        tag;
        } stage_t;
    endclass

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the shifter: shifts/rotates by DIST when enabled.
// Rotate muxing exists only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DIST = 1
) (
    input  logic [XLEN-1:0] i_data,
    input  shift_op_t       i_op,
    input  logic            i_en,
    output logic [XLEN-1:0] o_data_c
);

    always_comb begin
        o_data_c = i_data;
        if (i_en) begin
            case (i_op)
                SHIFT_OP_SLL: o_data_c = {i_data[XLEN-1-DIST:0], {DIST{1'b0}}};
                SHIFT_OP_SRL: o_data_c = {{DIST{1'b0}}, i_data[XLEN-1:DIST]};
                SHIFT_OP_SRA: o_data_c = {{DIST{i_data[XLEN-1]}}, i_data[XLEN-1:DIST]};
`ifdef SHIFT_PIPE_ROTATE_EN
                SHIFT_OP_ROL: o_data_c = {i_data[XLEN-1-DIST:0], i_data[XLEN-1:XLEN-DIST]};
                SHIFT_OP_ROR: o_data_c = {i_data[DIST-1:0], i_data[XLEN-1:DIST]};
`endif
                default:      o_data_c = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shift/rotate unit with valid/ready handshake and pass-through tag.
// Rotates (ROL/ROR) are built only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_data,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  shift_op_t               in_op,
    input  logic                    in_word,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy
);

    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned BASE  = SHW / PIPE_STAGES;
    localparam int unsigned EXTRA = SHW % PIPE_STAGES;

    typedef shift_stage_types#(.XLEN(XLEN), .TAG_W(TAG_W))::stage_t stage_t;

    // Index of the first mux level owned by stage k; earlier stages absorb the remainder.
    function automatic int unsigned first_level(input int unsigned k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    stage_t                 r_stage [PIPE_STAGES];
    stage_t                 w_src   [PIPE_STAGES];
    stage_t                 w_next  [PIPE_STAGES];
    logic [XLEN-1:0]        w_res   [PIPE_STAGES];
    logic [PIPE_STAGES:0]   w_go;
    logic [PIPE_STAGES-1:0] w_valid;
    logic [XLEN-1:0]        w_in_data;
    logic [SHW-1:0]         w_in_shamt;
    stage_t                 w_in;

    // Word ops run on a 64-bit datapath: pre-extend the operand, replicate it for rotates.
    if (XLEN == 64) begin : g_word_prep
        always_comb begin
            w_in_data  = in_data;
            w_in_shamt = in_shamt;
            if (in_word) begin
                w_in_shamt = {1'b0, in_shamt[4:0]};
                case (in_op)
                    SHIFT_OP_SRL:               w_in_data = {32'h0, in_data[31:0]};
                    SHIFT_OP_ROL, SHIFT_OP_ROR: w_in_data = {in_data[31:0], in_data[31:0]};
                    default:                    w_in_data = {{32{in_data[31]}}, in_data[31:0]};
                endcase
            end
        end
    end else begin : g_no_word_prep
        assign w_in_data  = in_data;
        assign w_in_shamt = in_shamt;
    end

    always_comb begin
        w_in       = '0;
        w_in.valid = in_valid;
        w_in.data  = w_in_data;
        w_in.op    = in_op;
        w_in.word  = (XLEN == 64) ? in_word : 1'b0;
        w_in.shamt = w_in_shamt;
        w_in.tag   = in_tag;
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int unsigned FIRST = first_level(k);
        localparam int unsigned LAST  = first_level(k + 1);

        if (k == 0) begin : g_src_in
            assign w_src[k] = w_in;
        end else begin : g_src_reg
            assign w_src[k] = r_stage[k-1];
        end

        for (genvar j = FIRST; j < LAST; j++) begin : g_level
            logic [XLEN-1:0] w_lin;
            logic [XLEN-1:0] w_out;

            if (j == FIRST) begin : g_first
                assign w_lin = w_src[k].data;
            end else begin : g_chain
                assign w_lin = g_level[j-1].w_out;
            end

            shift_level #(
                .XLEN (XLEN),
                .DIST (1 << (SHW - 1 - j))
            ) u_level (
                .i_data   (w_lin),
                .i_op     (w_src[k].op),
                .i_en     (w_src[k].shamt[SHW-1-j]),
                .o_data_c (w_out)
            );
        end

        // Final stage sign-extends word results from bit 31 before they are registered.
        if ((k == PIPE_STAGES - 1) && (XLEN == 64)) begin : g_word_ext
            logic [XLEN-1:0] w_raw;
            assign w_raw    = g_level[LAST-1].w_out;
            assign w_res[k] = w_src[k].word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
        end else begin : g_no_ext
            assign w_res[k] = g_level[LAST-1].w_out;
        end
    end

    // Advance chain: a stage may load when empty or when its successor moves on.
    always_comb begin
        w_go              = '0;
        w_valid           = '0;
        w_go[PIPE_STAGES] = out_ready;
        for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
            w_valid[k] = r_stage[k].valid;
            w_go[k]    = !r_stage[k].valid || w_go[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < int'(PIPE_STAGES); k++) begin
            w_next[k]      = w_src[k];
            w_next[k].data = w_res[k];
        end
    end

    // Payload is only captured with a valid op, so bubbles leave data/tag untouched.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(PIPE_STAGES); k++) begin
            if (rst) begin
                r_stage[k] <= '0;
            end else if (flush) begin
                r_stage[k].valid <= 1'b0;
            end else if (w_go[k]) begin
                if (w_src[k].valid) begin
                    r_stage[k] <= w_next[k];
                end else begin
                    r_stage[k].valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_go[0] && !flush;
    assign out_valid = r_stage[PIPE_STAGES-1].valid;
    assign out_data  = r_stage[PIPE_STAGES-1].data;
    assign out_tag   = r_stage[PIPE_STAGES-1].tag;
    assign busy      = |w_valid;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit/2-stage and 64-bit/4-stage instances.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam bit ROT =
`ifdef SHIFT_PIPE_ROTATE_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        shift_op_t   op;
        logic        word;
        logic [63:0] data;
        logic [5:0]  shamt;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic        a_in_valid, a_in_ready, a_in_word, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_shamt, a_in_tag, a_out_tag;
    shift_op_t   a_in_op;

    logic        b_in_valid, b_in_ready, b_in_word, b_out_valid, b_out_ready, b_busy;
    logic [63:0] b_in_data, b_out_data;
    logic [5:0]  b_in_shamt;
    logic [4:0]  b_in_tag, b_out_tag;
    shift_op_t   b_in_op;

    int checks = 0;
    int errors = 0;

    shift_pipe #(.XLEN(32), .PIPE_STAGES(2), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_shamt(a_in_shamt), .in_op(a_in_op), .in_word(a_in_word), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .busy(a_busy)
    );

    shift_pipe #(.XLEN(64), .PIPE_STAGES(4), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_op(b_in_op), .in_word(b_in_word), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input shift_op_t op, input logic [31:0] d, input logic [4:0] sh,
                           input logic [4:0] tag);
        a_in_valid = 1'b1;
        a_in_op    = op;
        a_in_word  = 1'b0;
        a_in_data  = d;
        a_in_shamt = sh;
        a_in_tag   = tag;
    endtask

    task automatic run32(input vec_t v, input int idx);
        drive32(v.op, v.data[31:0], v.shamt[4:0], v.tag);
        a_in_word = v.word;
        check($sformatf("v32[%0d] in_ready", idx), 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        check($sformatf("v32[%0d] early out_valid", idx), 64'(a_out_valid), 64'd0);
        step();
        check($sformatf("v32[%0d] out_valid", idx), 64'(a_out_valid), 64'd1);
        check($sformatf("v32[%0d] out_data", idx), 64'(a_out_data), 64'(v.exp[31:0]));
        check($sformatf("v32[%0d] out_tag", idx), 64'(a_out_tag), 64'(v.tag));
    endtask

    task automatic run64(input vec_t v, input int idx);
        b_in_valid = 1'b1;
        b_in_op    = v.op;
        b_in_word  = v.word;
        b_in_data  = v.data;
        b_in_shamt = v.shamt;
        b_in_tag   = v.tag;
        check($sformatf("v64[%0d] in_ready", idx), 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0;
        check($sformatf("v64[%0d] early out_valid", idx), 64'(b_out_valid), 64'd0);
        for (int i = 0; i < 3; i++) step();
        check($sformatf("v64[%0d] out_valid", idx), 64'(b_out_valid), 64'd1);
        check($sformatf("v64[%0d] out_data", idx), b_out_data, v.exp);
        check($sformatf("v64[%0d] out_tag", idx), 64'(b_out_tag), 64'(v.tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v32 [$];
        vec_t v64 [$];

        v32.push_back('{SHIFT_OP_SRA, 1'b0, 64'h8000_0000, 6'd31, 5'd7,  64'hFFFF_FFFF});
        v32.push_back('{SHIFT_OP_SRL, 1'b0, 64'h8000_0000, 6'd31, 5'd8,  64'h0000_0001});
        v32.push_back('{SHIFT_OP_SLL, 1'b0, 64'h0000_0001, 6'd31, 5'd9,  64'h8000_0000});
        v32.push_back('{SHIFT_OP_SLL, 1'b0, 64'h0000_00A5, 6'd0,  5'd1,  64'h0000_00A5});
        v32.push_back('{SHIFT_OP_SRA, 1'b0, 64'h7FFF_FFF0, 6'd4,  5'd2,  64'h07FF_FFFF});
        v32.push_back('{SHIFT_OP_SRA, 1'b0, 64'hF000_0000, 6'd4,  5'd3,  64'hFF00_0000});
        v32.push_back('{SHIFT_OP_SRL, 1'b0, 64'hDEAD_BEEF, 6'd16, 5'd4,  64'h0000_DEAD});
        v32.push_back('{SHIFT_OP_SLL, 1'b0, 64'hDEAD_BEEF, 6'd8,  5'd5,  64'hADBE_EF00});
        v32.push_back('{SHIFT_OP_SRA, 1'b1, 64'h8000_0000, 6'd1,  5'd6,  64'hC000_0000});
        v32.push_back('{SHIFT_OP_ROR, 1'b0, 64'h0000_0001, 6'd1,  5'd10,
                        ROT ? 64'h8000_0000 : 64'h0000_0001});
        v32.push_back('{SHIFT_OP_ROL, 1'b0, 64'h8000_0001, 6'd4,  5'd11,
                        ROT ? 64'h0000_0018 : 64'h8000_0001});
        v32.push_back('{SHIFT_OP_ROR, 1'b0, 64'h1234_5678, 6'd8,  5'd12,
                        ROT ? 64'h7812_3456 : 64'h1234_5678});
        v32.push_back('{3'b111,       1'b0, 64'h1234_5678, 6'd5,  5'd13, 64'h1234_5678});
        v32.push_back('{3'b101,       1'b0, 64'hDEAD_BEEF, 6'd3,  5'd14, 64'hDEAD_BEEF});

        v64.push_back('{SHIFT_OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd4,  5'd1, 64'h0000_0000_0800_0000});
        v64.push_back('{SHIFT_OP_SLL, 1'b1, 64'h0000_0000_0000_0001, 6'd31, 5'd2, 64'hFFFF_FFFF_8000_0000});
        v64.push_back('{SHIFT_OP_SLL, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 5'd3, 64'h8000_0000_0000_0000});
        v64.push_back('{SHIFT_OP_SRA, 1'b1, 64'h0000_0000_8000_0000, 6'd4,  5'd4, 64'hFFFF_FFFF_F800_0000});
        v64.push_back('{SHIFT_OP_SLL, 1'b1, 64'h0000_0000_0000_0001, 6'd33, 5'd5, 64'h0000_0000_0000_0002});
        v64.push_back('{SHIFT_OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF});
        v64.push_back('{SHIFT_OP_SRL, 1'b0, 64'hFFFF_0000_0000_0000, 6'd32, 5'd7, 64'h0000_0000_FFFF_0000});
        v64.push_back('{3'b110,       1'b1, 64'h0000_0000_8000_0000, 6'd9,  5'd8, 64'hFFFF_FFFF_8000_0000});
        v64.push_back('{SHIFT_OP_ROR, 1'b1, 64'h0000_0000_0000_0001, 6'd1,  5'd9,
                        ROT ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_0000_0001});
        v64.push_back('{SHIFT_OP_ROL, 1'b0, 64'h8000_0000_0000_0001, 6'd1,  5'd10,
                        ROT ? 64'h0000_0000_0000_0003 : 64'h8000_0000_0000_0001});
        v64.push_back('{SHIFT_OP_ROL, 1'b1, 64'h0000_0000_8000_0001, 6'd4,  5'd11,
                        ROT ? 64'h0000_0000_0000_0018 : 64'hFFFF_FFFF_8000_0001});

        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_in_word = 1'b0; a_in_data = '0; a_in_shamt = '0;
        a_in_op = SHIFT_OP_SLL; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_word = 1'b0; b_in_data = '0; b_in_shamt = '0;
        b_in_op = SHIFT_OP_SLL; b_in_tag = '0; b_out_ready = 1'b1;
        step();
        step();

        check("reset out_valid32", 64'(a_out_valid), 64'd0);
        check("reset out_data32", 64'(a_out_data), 64'd0);
        check("reset out_tag32", 64'(a_out_tag), 64'd0);
        check("reset busy32", 64'(a_busy), 64'd0);
        check("reset in_ready32", 64'(a_in_ready), 64'd1);
        check("reset out_valid64", 64'(b_out_valid), 64'd0);
        check("reset out_data64", b_out_data, 64'd0);
        check("reset busy64", 64'(b_busy), 64'd0);
        rst = 1'b0;
        step();

        foreach (v32[i]) run32(v32[i], i);
        foreach (v64[i]) run64(v64[i], i);

        // Back-to-back SLL of 1 by 0..3: one result per cycle, in order.
        for (int i = 0; i < 4; i++) begin
            drive32(SHIFT_OP_SLL, 32'h1, 5'(i), 5'(i));
            step();
            if (i >= 1) begin
                check($sformatf("b2b[%0d] out_valid", i - 1), 64'(a_out_valid), 64'd1);
                check($sformatf("b2b[%0d] out_data", i - 1), 64'(a_out_data), 64'(32'h1 << (i - 1)));
            end
        end
        a_in_valid = 1'b0;
        step();
        check("b2b[3] out_valid", 64'(a_out_valid), 64'd1);
        check("b2b[3] out_data", 64'(a_out_data), 64'h8);
        step();
        check("b2b drained", 64'(a_out_valid), 64'd0);

        // Fill, stall 3 cycles, release: hold stable, then in-order delivery with no loss.
        a_out_ready = 1'b0;
        drive32(SHIFT_OP_SLL, 32'h10A, 5'd0, 5'd10);
        step();
        drive32(SHIFT_OP_SLL, 32'h10B, 5'd0, 5'd11);
        step();
        drive32(SHIFT_OP_SLL, 32'h10C, 5'd0, 5'd12);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall[%0d] in_ready", i), 64'(a_in_ready), 64'd0);
            check($sformatf("stall[%0d] out_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("stall[%0d] out_data", i), 64'(a_out_data), 64'h10A);
            check($sformatf("stall[%0d] out_tag", i), 64'(a_out_tag), 64'd10);
            step();
        end
        a_out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        check("release 2nd out_data", 64'(a_out_data), 64'h10B);
        check("release 2nd out_tag", 64'(a_out_tag), 64'd11);
        step();
        check("release 3rd out_valid", 64'(a_out_valid), 64'd1);
        check("release 3rd out_data", 64'(a_out_data), 64'h10C);
        check("release 3rd out_tag", 64'(a_out_tag), 64'd12);
        step();
        check("release drained", 64'(a_out_valid), 64'd0);

        // Flush with two operations in flight.
        drive32(SHIFT_OP_SRL, 32'hF0, 5'd4, 5'd20);
        step();
        drive32(SHIFT_OP_SRL, 32'hF00, 5'd4, 5'd21);
        step();
        check("preflush busy", 64'(a_busy), 64'd1);
        drive32(SHIFT_OP_SRL, 32'hF000, 5'd4, 5'd22);
        flush = 1'b1;
        #1;
        check("flush in_ready", 64'(a_in_ready), 64'd0);
        step();
        flush = 1'b0;
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("postflush[%0d] out_valid", i), 64'(a_out_valid), 64'd0);
            check($sformatf("postflush[%0d] busy", i), 64'(a_busy), 64'd0);
            step();
        end

        // Reset in the middle of a stream.
        drive32(SHIFT_OP_SLL, 32'hFFFF, 5'd4, 5'd30);
        step();
        drive32(SHIFT_OP_SLL, 32'hFFFF, 5'd8, 5'd31);
        step();
        check("prereset out_valid", 64'(a_out_valid), 64'd1);
        check("prereset out_data", 64'(a_out_data), 64'hF_FFF0);
        rst = 1'b1;
        a_in_valid = 1'b0;
        step();
        check("midreset out_valid", 64'(a_out_valid), 64'd0);
        check("midreset out_data", 64'(a_out_data), 64'd0);
        check("midreset out_tag", 64'(a_out_tag), 64'd0);
        check("midreset busy", 64'(a_busy), 64'd0);
        check("midreset in_ready", 64'(a_in_ready), 64'd1);
        rst = 1'b0;
        step();
        check("postreset out_valid", 64'(a_out_valid), 64'd0);
        check("postreset out_data", 64'(a_out_data), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised shift/rotate unit for the execute stage. It generalises the single-cycle 32-bit shifter to XLEN of 32 or 64, a configurable number of register stages, RV64 word-mode operations, optional rotates, and a valid/ready handshake with a tag that passes through alongside the data. It sits between issue and writeback, and its output can be stalled by writeback back-pressure.

## Interface
- XLEN, 32: datapath width; legal values are 32 or 64.
- PIPE_STAGES, 2: number of register stages, 1..$clog2(XLEN).
- TAG_W, 5: width of the pass-through tag (destination register index).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discards every in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_data  in  XLEN  operand
- in_shamt  in  $clog2(XLEN)  shift amount
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; other codes are pass-through
- in_word  in  1  32-bit word op; ignored when XLEN=32
- in_tag  in  TAG_W  carried unchanged to out_tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  OR of all stage valid bits

## Operation
- The shifter has $clog2(XLEN) mux levels, applied largest distance first. Levels are split across PIPE_STAGES; when the split is uneven, the earlier stages take the extra levels. Each stage ends in a register holding valid, data, op, word, remaining shamt bits and tag.
- SLL fills with 0. SRL fills with 0. SRA fills with the operand MSB. ROL and ROR wrap the bits that shift out. A shamt of 0 returns the operand unchanged.
- Word mode (XLEN=64, in_word=1):
  - The operation uses in_data[31:0] and shamt[4:0]; shamt[5] is ignored.
  - SRL zero-extends the 32-bit source before shifting. SRA sign-extends it from bit 31.
  - Rotates wrap within 32 bits.
  - The final 32-bit result is sign-extended from bit 31 to 64 bits.
- An illegal op code returns in_data unchanged, with word-mode sign extension applied if in_word=1.
- Stage k may advance when it is empty or stage k+1 advances. The last stage advances when out_ready=1. in_ready = !valid0 || advance0, a combinational chain from out_ready.
- flush: all valid bits go to 0 on the next edge. in_ready is 0 during the flush cycle, so a request presented in that cycle is not accepted. flush has priority over acceptance and advancement.

## Timing
- On reset, every valid bit is 0 and every data and tag register is 0. After reset: out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1.
- Latency is PIPE_STAGES cycles from acceptance to out_valid, with no stall. Throughput is 1 operation per cycle.
- While out_valid=1 && out_ready=0, out_data and out_tag hold stable and no stage overwrites an occupied register.
- A full pipeline with out_ready=1 accepts a new request in the same cycle the oldest result retires.
- Results leave in acceptance order.
- rst or flush in the middle of a stream: no pre-reset or pre-flush result is ever presented.

## Configuration
- SHIFT_PIPE_ROTATE_EN defined: ROL and ROR are implemented as described above.
- SHIFT_PIPE_ROTATE_EN undefined: codes 011 and 100 are illegal and behave as pass-through. The rotate muxing is removed from every level.

## Structure
- Package shift_pkg holds:
  - the op encodings SHIFT_OP_SLL, SHIFT_OP_SRL, SHIFT_OP_SRA, SHIFT_OP_ROL, SHIFT_OP_ROR;
  - the op typedef;
  - the stage-register struct typedef, parametrised by XLEN and TAG_W.
- Sub-module shift_level is one combinational mux level, parametrised by XLEN and DIST. shift_pipe instantiates one per level and places the stage registers between groups.

## Test plan
- XLEN=32, PIPE_STAGES=2: SRA 0x80000000 by 31, tag 7 -> out_data 0xFFFFFFFF and out_tag 7 exactly 2 cycles after acceptance. SRL of the same operand by 31 -> 0x00000001.
- Four back-to-back SLL operations of 0x1 by 0,1,2,3 with out_ready=1 -> outputs 0x1, 0x2, 0x4, 0x8 on four consecutive cycles.
- Full pipeline, then out_ready=0 for 3 cycles -> in_ready=0, out_data stable for all 3 cycles; after release, every result is delivered in order and none is lost or duplicated.
- XLEN=64:
  - SRLW of 0xFFFFFFFF_80000000 by 4 -> 0x00000000_08000000.
  - SLLW of 0x1 by 31 -> 0xFFFFFFFF_80000000.
  - SLL of 0x1 by 63 -> 0x80000000_00000000.
- ROR 0x00000001 by 1 -> 0x80000000 with SHIFT_PIPE_ROTATE_EN defined; 0x00000001 without it. Op code 111 -> the operand unchanged.
- flush asserted with 2 operations in flight -> out_valid=0 from the next cycle and no stale result appears. rst asserted mid-stream -> every output returns to its reset value on the next edge.
